// File: rtl/ipsxe_floating_point_op_sequencer.sv
// Operation sequencer for the floating-point example design.
// Walks the operation ROM one entry at a time. Each entry is decoded and
// issued to the FP core with a valid/ready handshake. The sequencer then
// waits for the result, with a timeout. Completed operations are counted,
// and done/timeout status is reported to the example-design top.
module ipsxe_floating_point_op_sequencer #(
  parameter int ADDR_W         = 4,
  parameter int NUM_ENTRIES    = 16,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_dout,
  output logic [2:0]        op_code,
  output logic [1:0]        round_mode,
  output logic              op_valid,
  input  logic              op_ready,
  input  logic              res_valid,
  output logic              res_ready,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  op_count
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ENTRIES - 1);
  // The timer starts at 0 on the first WAIT_RES cycle.
  // A value of LIMIT-1 therefore marks the LIMIT-th cycle spent waiting.
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_ISSUE, S_WAIT_RES, S_DONE
  } state_t;

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic             last;

  // The reserved ROM bits [7:6] carry no meaning for the sequencer.
  logic unused_rsvd;
  assign unused_rsvd = ^rom_dout[7:6];

  // Sequencer FSM. rom_addr doubles as the entry pointer.
  // It is registered, so FETCH presents it to the ROM, and LATCH sees the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      timer       <= '0;
      last        <= 1'b0;
      rom_addr    <= '0;
      op_code     <= '0;
      round_mode  <= '0;
      op_valid    <= 1'b0;
      res_ready   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      op_count    <= '0;
    end else if (abort) begin
      // Abort wins over every transition.
      // The count and the error flag are left as they are, for inspection.
      state     <= S_IDLE;
      op_valid  <= 1'b0;
      res_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            rom_addr    <= '0;
            op_count    <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b1;
            state       <= S_FETCH;
          end
        end
        S_FETCH: state <= S_LATCH;
        S_LATCH: begin
          op_code    <= rom_dout[5:3];
          round_mode <= rom_dout[2:1];
          last       <= rom_dout[0];
          op_valid   <= 1'b1;
          state      <= S_ISSUE;
        end
        S_ISSUE: begin
          if (op_ready) begin
            op_valid  <= 1'b0;
            res_ready <= 1'b1;
            timer     <= '0;
            state     <= S_WAIT_RES;
          end
        end
        S_WAIT_RES: begin
          // A result arriving on the final timer cycle still counts as success.
          if (res_valid) begin
            if (op_count != '1) op_count <= op_count + 1'b1;
            res_ready <= 1'b0;
            if (last || rom_addr == LAST_ADDR) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              rom_addr <= rom_addr + 1'b1;
              state    <= S_FETCH;
            end
          end else if (timer == TMR_LAST) begin
            timeout_err <= 1'b1;
            res_ready   <= 1'b0;
            done        <= 1'b1;
            state       <= S_DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ipsxe_floating_point_op_sequencer.sv
// Testbench for ipsxe_floating_point_op_sequencer.
// The stimulus pushes the expected issued operations and the expected
// end-of-run status into queues. Monitors pop those entries and compare them
// when the DUT presents a handshake or a done pulse.
module tb_ipsxe_floating_point_op_sequencer;

  localparam int TIMEOUT = 1023;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  rom_addr;
  logic [7:0]  rom_dout = 8'h00;
  logic [2:0]  op_code;
  logic [1:0]  round_mode;
  logic        op_valid;
  logic        op_ready = 1'b0;
  logic        res_valid = 1'b0;
  logic        res_ready;
  logic        busy;
  logic        done;
  logic        timeout_err;
  logic [15:0] op_count;

  ipsxe_floating_point_op_sequencer #(
    .ADDR_W(4), .NUM_ENTRIES(16), .TIMEOUT_CYCLES(TIMEOUT), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .rom_addr(rom_addr), .rom_dout(rom_dout),
    .op_code(op_code), .round_mode(round_mode),
    .op_valid(op_valid), .op_ready(op_ready),
    .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .done(done), .timeout_err(timeout_err), .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [1:0] rnd;
    logic [3:0] addr;
    int         vc;
  } op_t;
  typedef struct {
    int   cnt;
    logic err;
    bit   chk_to;
  } run_t;

  op_t  exp_ops[$];
  run_t exp_runs[$];

  int errs = 0;
  int checks = 0;
  int done_cnt = 0;
  int cyc = 0;
  int hs_cyc = 0;

  // Core-model controls, written only by the stimulus process.
  int hold_cfg = 0;
  int no_resp_idx = -1;
  int abort_idx = -1;

  logic [7:0] rom [16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Registered ROM with a one-cycle read.
  always @(posedge clk) rom_dout <= rom[rom_addr];

  // Core model. Drives its inputs 1 time unit after the edge.
  // Op 0 can be held off for hold_cfg cycles.
  // A result returns 2 cycles after accept.
  // One op can be left unanswered, and one response can carry an abort.
  int acc_n = 0, hold_vc = 0, res_cnt = 0;
  bit pend = 0;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      op_ready = 0; res_valid = 0; abort = 0;
      pend = 0; acc_n = 0; hold_vc = 0;
    end else begin
      res_valid = 0;
      abort = 0;
      if (!busy) acc_n = 0;
      if (pend) begin
        if (res_cnt > 1) res_cnt--;
        else begin
          pend = 0;
          if (acc_n - 1 != no_resp_idx) begin
            res_valid = 1;
            if (acc_n - 1 == abort_idx) abort = 1;
          end
        end
      end
      if (op_valid) begin
        if (acc_n == 0 && hold_vc < hold_cfg) begin
          op_ready = 0;
          hold_vc++;
        end else if (!op_ready) begin
          op_ready = 1;
          acc_n++;
          pend = 1;
          res_cnt = 2;
        end
      end else begin
        op_ready = 0;
        hold_vc = 0;
      end
    end
  end

  // Op monitor. valid & ready at the negedge means a handshake at the next edge.
  int vcnt = 0;
  logic [2:0] prev_op = '0;
  logic [1:0] prev_rnd = '0;
  always @(negedge clk) begin
    if (!rst && op_valid) begin
      vcnt++;
      if (vcnt > 1) begin
        chk("op_code_stable", int'(op_code), int'(prev_op));
        chk("round_mode_stable", int'(round_mode), int'(prev_rnd));
      end
      prev_op = op_code;
      prev_rnd = round_mode;
      if (op_ready) begin
        if (exp_ops.size() == 0) begin
          chk("unexpected_op", 1, 0);
        end else begin
          op_t e;
          e = exp_ops.pop_front();
          chk("op_code", int'(op_code), int'(e.op));
          chk("round_mode", int'(round_mode), int'(e.rnd));
          chk("rom_addr", int'(rom_addr), int'(e.addr));
          chk("issue_cycles", vcnt, e.vc);
        end
        hs_cyc = cyc + 1;  // cycle count once the handshake edge has passed
        vcnt = 0;
      end
    end else begin
      vcnt = 0;
    end
  end

  // Run monitor: checks the end-of-run status and that done is a single pulse.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (prev_done) chk("done_one_cycle", int'(done), 0);
    if (done) begin
      done_cnt++;
      if (exp_runs.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        run_t r;
        r = exp_runs.pop_front();
        chk("run_op_count", int'(op_count), r.cnt);
        chk("run_timeout_err", int'(timeout_err), int'(r.err));
        if (r.chk_to) chk("timeout_wait_cycles", cyc - hs_cyc, TIMEOUT);
      end
    end
    prev_done = done;
  end

  task automatic nclk(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic pulse_start();
    start = 1; nclk(1); start = 0;
  endtask

  task automatic wait_runs(input int target, input int maxc);
    int n = 0;
    while (done_cnt < target && n < maxc) begin nclk(1); n++; end
    chk("run_finished_in_budget", int'(done_cnt >= target), 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rom_addr"}, int'(rom_addr), 0);
    chk({tag, "_op_code"}, int'(op_code), 0);
    chk({tag, "_round_mode"}, int'(round_mode), 0);
    chk({tag, "_op_valid"}, int'(op_valid), 0);
    chk({tag, "_res_ready"}, int'(res_ready), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_timeout_err"}, int'(timeout_err), 0);
    chk({tag, "_op_count"}, int'(op_count), 0);
  endtask

  task automatic fill_rom(input logic [7:0] v);
    for (int i = 0; i < 16; i++) rom[i] = v;
  endtask

  task automatic push_ops(input int n, input logic [2:0] op);
    for (int i = 0; i < n; i++) exp_ops.push_back('{op, 2'b00, 4'(i), 1});
  endtask

  initial begin
    fill_rom(8'h08);
    rst = 1;
    nclk(3);
    check_all_zero("reset");
    rst = 0;
    nclk(2);

    // Full 16-entry walk; a second start mid-run must be ignored.
    push_ops(16, 3'b001);
    exp_runs.push_back('{16, 1'b0, 1'b0});
    pulse_start();
    nclk(20);
    pulse_start();
    wait_runs(1, 400);
    nclk(10);
    chk("walk_done_count", done_cnt, 1);
    chk("walk_busy_after", int'(busy), 0);
    chk("walk_rom_addr_end", int'(rom_addr), 15);

    // Last flag on entry 2, with op 0 held off for 5 cycles.
    // The latency to the first op_valid is checked in this run.
    rom[0] = 8'h2C;   // op 101, rnd 10
    rom[1] = 8'hD2;   // reserved 11, op 010, rnd 01
    rom[2] = 8'h09;   // op 001, rnd 00, last
    hold_cfg = 5;
    exp_ops.push_back('{3'b101, 2'b10, 4'd0, 6});
    exp_ops.push_back('{3'b010, 2'b01, 4'd1, 1});
    exp_ops.push_back('{3'b001, 2'b00, 4'd2, 1});
    exp_runs.push_back('{3, 1'b0, 1'b0});
    pulse_start();
    chk("latency_c1_op_valid", int'(op_valid), 0);
    chk("latency_c1_busy", int'(busy), 1);
    nclk(1);
    chk("latency_c2_op_valid", int'(op_valid), 0);
    nclk(1);
    chk("latency_c3_op_valid", int'(op_valid), 1);
    wait_runs(2, 200);
    nclk(5);
    chk("last_rom_addr_stop", int'(rom_addr), 2);
    chk("last_done_count", done_cnt, 2);
    hold_cfg = 0;

    // Result timeout on op 4.
    fill_rom(8'h08);
    no_resp_idx = 4;
    push_ops(5, 3'b001);
    exp_runs.push_back('{4, 1'b1, 1'b1});
    pulse_start();
    wait_runs(3, 1500);
    nclk(2);
    chk("timeout_sticky", int'(timeout_err), 1);
    no_resp_idx = -1;

    // Abort during WAIT_RES of op 7, with res_valid in the same cycle.
    // The new start must also clear the timeout flag.
    abort_idx = 7;
    push_ops(8, 3'b001);
    pulse_start();
    chk("start_clears_timeout", int'(timeout_err), 0);
    begin
      int n = 0;
      while (busy && n < 300) begin nclk(1); n++; end
      chk("abort_reached_idle", int'(busy), 0);
    end
    nclk(2);
    chk("abort_op_count", int'(op_count), 7);
    chk("abort_no_done", done_cnt, 3);
    chk("abort_op_valid", int'(op_valid), 0);
    chk("abort_res_ready", int'(res_ready), 0);
    chk("abort_ops_drained", exp_ops.size(), 0);
    abort_idx = -1;

    // Reset while an op sits in ISSUE.
    hold_cfg = 10;
    pulse_start();
    begin
      int n = 0;
      while (!op_valid && n < 20) begin nclk(1); n++; end
      chk("rst_test_reached_issue", int'(op_valid), 1);
    end
    nclk(2);
    rst = 1;
    nclk(1);
    rst = 0;
    check_all_zero("mid_rst");
    hold_cfg = 0;
    nclk(5);
    chk("final_done_count", done_cnt, 3);
    chk("final_runs_drained", exp_runs.size(), 0);
    chk("final_ops_drained", exp_ops.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
